// File: rtl/adder_rr_scheduler.sv
// Round-robin scheduler sharing one external combinational adder among NREQ requesters.
// Each transaction goes IDLE (grant) -> EXEC (adder settles) -> RESP (result held until taken).
module adder_rr_scheduler #(
    parameter int NREQ = 4,
    parameter int W    = 31,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NREQ-1:0]     req_valid,
    output logic [NREQ-1:0]     req_ready,
    input  logic [NREQ*W-1:0]   req_x,
    input  logic [NREQ*W-1:0]   req_y,
    output logic [W-1:0]        add_x,
    output logic [W-1:0]        add_y,
    input  logic [W:0]          add_s,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [IDW-1:0]      rsp_id,
    output logic [W:0]          rsp_sum,
    output logic                busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [IDW-1:0]     rr_ptr_q, rr_ptr_d;
    logic [IDW-1:0]     id_q, id_d;
    logic [W-1:0]       add_x_q, add_x_d;
    logic [W-1:0]       add_y_q, add_y_d;
    logic [W:0]         rsp_sum_q, rsp_sum_d;
    logic [IDW-1:0]     rsp_id_q, rsp_id_d;
    logic               rsp_valid_q, rsp_valid_d;

    logic [W-1:0]       x_arr [NREQ];
    logic [W-1:0]       y_arr [NREQ];
    logic               grant_found;
    logic [IDW-1:0]     grant_idx;
    logic [IDW-1:0]     next_ptr;

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
            assign x_arr[gi] = req_x[gi*W +: W];
            assign y_arr[gi] = req_y[gi*W +: W];
            assign req_ready[gi] = (state_q == ST_IDLE) && grant_found
                                   && (grant_idx == IDW'(gi));
        end
    endgenerate

    // Scan offsets from farthest to nearest so the last hit is the first valid
    // requester at or after rr_ptr.
    always_comb begin
        int             cand;
        logic [IDW-1:0] cand_idx;
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = 0;
        cand_idx    = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            cand = int'(rr_ptr_q) + k;
            if (cand >= NREQ) begin
                cand = cand - NREQ;
            end
            cand_idx = IDW'(cand);
            if (req_valid[cand_idx]) begin
                grant_found = 1'b1;
                grant_idx   = cand_idx;
            end
        end
    end

    assign next_ptr = (int'(grant_idx) == NREQ - 1) ? '0 : grant_idx + 1'b1;

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        id_d        = id_q;
        add_x_d     = add_x_q;
        add_y_d     = add_y_q;
        rsp_sum_d   = rsp_sum_q;
        rsp_id_d    = rsp_id_q;
        rsp_valid_d = rsp_valid_q;
        case (state_q)
            ST_IDLE: begin
                if (grant_found) begin
                    add_x_d  = x_arr[grant_idx];
                    add_y_d  = y_arr[grant_idx];
                    id_d     = grant_idx;
                    rr_ptr_d = next_ptr;
                    state_d  = ST_EXEC;
                end
            end
            ST_EXEC: begin
                rsp_sum_d   = add_s;
                rsp_id_d    = id_q;
                rsp_valid_d = 1'b1;
                state_d     = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            rr_ptr_q    <= '0;
            id_q        <= '0;
            add_x_q     <= '0;
            add_y_q     <= '0;
            rsp_sum_q   <= '0;
            rsp_id_q    <= '0;
            rsp_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            id_q        <= id_d;
            add_x_q     <= add_x_d;
            add_y_q     <= add_y_d;
            rsp_sum_q   <= rsp_sum_d;
            rsp_id_q    <= rsp_id_d;
            rsp_valid_q <= rsp_valid_d;
        end
    end

    assign add_x     = add_x_q;
    assign add_y     = add_y_q;
    assign rsp_sum   = rsp_sum_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_valid = rsp_valid_q;
    assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_adder_rr_scheduler.sv
// Directed bench for adder_rr_scheduler; the shared adder is modelled here as a plain sum.
module tb_adder_rr_scheduler;

    localparam int NREQ = 4;
    localparam int W    = 31;
    localparam int IDW  = 2;

    logic                clk = 1'b0;
    logic                rst;
    logic [NREQ-1:0]     req_valid;
    logic [NREQ-1:0]     req_ready;
    logic [NREQ*W-1:0]   req_x;
    logic [NREQ*W-1:0]   req_y;
    logic [W-1:0]        add_x;
    logic [W-1:0]        add_y;
    logic [W:0]          add_s;
    logic                rsp_valid;
    logic                rsp_ready;
    logic [IDW-1:0]      rsp_id;
    logic [W:0]          rsp_sum;
    logic                busy;

    int n_assert = 0;
    int n_fail   = 0;

    adder_rr_scheduler #(.NREQ(NREQ), .W(W), .IDW(IDW)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_x     (req_x),
        .req_y     (req_y),
        .add_x     (add_x),
        .add_y     (add_y),
        .add_s     (add_s),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_sum   (rsp_sum),
        .busy      (busy)
    );

    // External shared adder
    assign add_s = {1'b0, add_x} + {1'b0, add_y};

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_op(input int i, input logic [W-1:0] x, input logic [W-1:0] y);
        req_x[i*W +: W] = x;
        req_y[i*W +: W] = y;
    endtask

    function automatic int model_grant(input int ptr, input logic [NREQ-1:0] mask);
        int g;
        g = -1;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (mask[(ptr + k) % NREQ]) g = (ptr + k) % NREQ;
        end
        return g;
    endfunction

    // Hand-computed operand/sum table for the fairness sweep
    logic [W-1:0] tx [NREQ];
    logic [W-1:0] ty [NREQ];
    logic [W:0]   ts [NREQ];
    int           order [5];

    initial begin
        logic [W-1:0]    rx [NREQ];
        logic [W-1:0]    ry [NREQ];
        logic [NREQ-1:0] mask;
        logic [NREQ-1:0] onehot;
        int              ptr;
        int              g;
        int              d;

        tx[0] = 31'h0000_0011; ty[0] = 31'h0000_0100; ts[0] = 32'h0000_0111;
        tx[1] = 31'h0000_0022; ty[1] = 31'h0000_0200; ts[1] = 32'h0000_0222;
        tx[2] = 31'h4000_0000; ty[2] = 31'h4000_0000; ts[2] = 32'h8000_0000;
        tx[3] = 31'h7FFF_FFFF; ty[3] = 31'h0000_0002; ts[3] = 32'h8000_0001;
        order[0] = 0; order[1] = 1; order[2] = 2; order[3] = 3; order[4] = 0;

        rst = 1'b1; req_valid = '0; req_x = '0; req_y = '0; rsp_ready = 1'b0;
        step(); step();
        rst = 1'b0;
        settle();
        chk("reset_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("reset_req_ready", 64'(req_ready), 64'd0);
        chk("reset_busy",      64'(busy),      64'd0);
        chk("reset_add_x",     64'(add_x),     64'd0);
        chk("reset_add_y",     64'(add_y),     64'd0);
        chk("reset_rsp_sum",   64'(rsp_sum),   64'd0);
        chk("reset_rsp_id",    64'(rsp_id),    64'd0);
        $display("reset: rsp_valid=%0d busy=%0d", rsp_valid, busy);

        // Single add on requester 2
        set_op(2, 31'h7FFF_FFFF, 31'h0000_0001);
        req_valid = 4'b0100;
        settle();
        chk("t1_ready", 64'(req_ready), 64'b0100);
        step();
        req_valid = '0;
        settle();
        chk("t1_exec_busy",  64'(busy),      64'd1);
        chk("t1_exec_valid", 64'(rsp_valid), 64'd0);
        chk("t1_add_x",      64'(add_x),     64'h7FFF_FFFF);
        chk("t1_add_y",      64'(add_y),     64'h1);
        step();
        chk("t1_rsp_valid", 64'(rsp_valid), 64'd1);
        chk("t1_rsp_sum",   64'(rsp_sum),   64'h0_8000_0000);
        chk("t1_rsp_id",    64'(rsp_id),    64'd2);
        rsp_ready = 1'b1;
        step();
        chk("t1_done_valid", 64'(rsp_valid), 64'd0);
        chk("t1_done_busy",  64'(busy),      64'd0);
        $display("t1: single add sum=0x%0h id=%0d", rsp_sum, rsp_id);

        // Fairness: all valid from rr_ptr=0, one accept every 3 cycles
        rsp_ready = 1'b0; rst = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i < NREQ; i++) set_op(i, tx[i], ty[i]);
        req_valid = 4'b1111;
        rsp_ready = 1'b1;
        for (int n = 0; n < 5; n++) begin
            settle();
            onehot = '0;
            onehot[order[n]] = 1'b1;
            chk("t2_grant", 64'(req_ready), 64'(onehot));
            step();
            chk("t2_exec_ready", 64'(req_ready), 64'd0);
            step();
            chk("t2_rsp_valid", 64'(rsp_valid), 64'd1);
            chk("t2_rsp_id",    64'(rsp_id),    64'(order[n]));
            chk("t2_rsp_sum",   64'(rsp_sum),   64'(ts[order[n]]));
            step();
            chk("t2_idle_valid", 64'(rsp_valid), 64'd0);
            $display("t2: grant %0d id=%0d sum=0x%0h", n, rsp_id, rsp_sum);
        end

        // Backpressure on requester 1 (rr_ptr is now 1)
        req_valid = 4'b0010;
        rsp_ready = 1'b0;
        settle();
        chk("t3_grant", 64'(req_ready), 64'b0010);
        step();
        req_valid = '0;
        step();
        req_valid = 4'b1111;
        for (int c = 0; c < 5; c++) begin
            settle();
            chk("t3_hold_valid", 64'(rsp_valid), 64'd1);
            chk("t3_hold_sum",   64'(rsp_sum),   64'h222);
            chk("t3_hold_id",    64'(rsp_id),    64'd1);
            chk("t3_hold_ready", 64'(req_ready), 64'd0);
            step();
        end
        rsp_ready = 1'b1;
        req_valid = '0;
        step();
        chk("t3_done_valid", 64'(rsp_valid), 64'd0);
        rsp_ready = 1'b0;
        $display("t3: backpressure released, rsp_valid=%0d", rsp_valid);

        // Maximum and zero operands
        set_op(0, 31'h7FFF_FFFF, 31'h7FFF_FFFF);
        req_valid = 4'b0001;
        step();
        req_valid = '0;
        step();
        chk("t4_max_sum", 64'(rsp_sum), 64'h0_FFFF_FFFE);
        chk("t4_max_id",  64'(rsp_id),  64'd0);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        step(); step();
        chk("t4_hold_add_x", 64'(add_x), 64'h7FFF_FFFF);
        set_op(3, 31'h0, 31'h0);
        req_valid = 4'b1000;
        step();
        req_valid = '0;
        step();
        chk("t4_zero_sum", 64'(rsp_sum), 64'd0);
        chk("t4_zero_id",  64'(rsp_id),  64'd3);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        $display("t4: max/zero operands done");

        // Reset in RESP drops the pending result
        set_op(2, 31'h0000_1234, 31'h0000_4321);
        req_valid = 4'b0100;
        step();
        req_valid = '0;
        step();
        chk("t5_pre_valid", 64'(rsp_valid), 64'd1);
        rst = 1'b1;
        rsp_ready = 1'b1;
        step();
        rst = 1'b0;
        rsp_ready = 1'b0;
        settle();
        chk("t5_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("t5_busy",      64'(busy),      64'd0);
        chk("t5_rsp_sum",   64'(rsp_sum),   64'd0);
        chk("t5_add_x",     64'(add_x),     64'd0);
        req_valid = 4'b1111;
        settle();
        chk("t5_ptr_zero", 64'(req_ready), 64'b0001);
        set_op(3, 31'h5, 31'h7);
        req_valid = 4'b1000;
        settle();
        chk("t5_grant3", 64'(req_ready), 64'b1000);
        step();
        req_valid = '0;
        step();
        chk("t5_sum", 64'(rsp_sum), 64'hC);
        chk("t5_id",  64'(rsp_id),  64'd3);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        $display("t5: reset in RESP, fresh req 3 sum=0x%0h", rsp_sum);

        // Random operands and valid masks against the rotating-priority model (rr_ptr=0 now)
        ptr = 0;
        for (int n = 0; n < 150; n++) begin
            mask = NREQ'($urandom_range(1, 15));
            for (int i = 0; i < NREQ; i++) begin
                rx[i] = W'($urandom());
                ry[i] = W'($urandom());
                set_op(i, rx[i], ry[i]);
            end
            req_valid = mask;
            settle();
            g = model_grant(ptr, mask);
            onehot = '0;
            onehot[g] = 1'b1;
            chk("t6_grant", 64'(req_ready), 64'(onehot));
            step();
            ptr = (g + 1) % NREQ;
            req_valid = NREQ'($urandom_range(0, 15));
            step();
            d = $urandom_range(0, 3);
            for (int c = 0; c < d; c++) begin
                chk("t6_wait_ready", 64'(req_ready), 64'd0);
                step();
            end
            rsp_ready = 1'b1;
            settle();
            chk("t6_rsp_valid", 64'(rsp_valid), 64'd1);
            chk("t6_rsp_id",    64'(rsp_id),    64'(g));
            chk("t6_rsp_sum",   64'(rsp_sum),   64'({1'b0, rx[g]} + {1'b0, ry[g]}));
            $display("t6: txn %0d mask=%b id=%0d sum=0x%0h", n, mask, rsp_id, rsp_sum);
            step();
            req_valid = '0;
            rsp_ready = 1'b0;
            settle();
            chk("t6_idle_valid", 64'(rsp_valid), 64'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
